// File: rtl/mc_control_if.sv
// Control bus between the multi-cycle MIPS main control unit and its datapath.
// The controller samples opcode/zero and drives every write enable and mux select.
interface mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero,
        output pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, alu_op, instr_done, illegal, state
    );

    modport slave (
        output opcode, zero,
        input  pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
               alu_src_a, alu_src_b, alu_op, instr_done, illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Control outputs are registered from the next state; only BEQ's pc_we and illegal look at live inputs.
module mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);

    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BEQ_EX   = 4'd9,
        J_EX     = 4'd10,
        ADDI_EX  = 4'd11,
        ADDI_WB  = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_we;
        logic       ir_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    state_t     state_reg;
    state_t     state_next;
    ctrl_t      ctrl_reg;
    logic [5:0] op_reg;
    logic       op_legal;

    always_comb begin
        op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW)  ||
                   (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                   (bus.opcode == OP_ADDI)  || (bus.opcode == OP_J);
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            RST:      state_next = FETCH;
            FETCH:    state_next = DECODE;
            DECODE: begin
                if (bus.opcode == OP_RTYPE)                           state_next = RTYPE_EX;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)  state_next = MEMADR;
                else if (bus.opcode == OP_BEQ)                        state_next = BEQ_EX;
                else if (bus.opcode == OP_J)                          state_next = J_EX;
                else if (bus.opcode == OP_ADDI)                       state_next = ADDI_EX;
                else                                                  state_next = FETCH;
            end
            // Only lw/sw reach MEMADR, so the latched opcode picks between them.
            MEMADR:   state_next = (op_reg == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            RTYPE_EX: state_next = RTYPE_WB;
            ADDI_EX:  state_next = ADDI_WB;
            default:  state_next = FETCH;
        endcase
    end

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.ir_we = 1'b1; c.pc_we = 1'b1; c.alu_src_b = 2'd1; end
            DECODE:   c.alu_src_b = 2'd3;
            MEMADR,
            ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            MEMRD:    c.iord = 1'b1;
            MEMWR:    begin c.iord = 1'b1; c.mem_we = 1'b1; c.instr_done = 1'b1; end
            MEMWB:    begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            RTYPE_EX: begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
            RTYPE_WB: begin c.reg_we = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            ADDI_WB:  begin c.reg_we = 1'b1; c.instr_done = 1'b1; end
            // pc_we for BEQ comes from the live zero flag, not from here.
            BEQ_EX:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1;
                            c.instr_done = 1'b1; end
            J_EX:     begin c.pc_we = 1'b1; c.pc_src = 2'd2; c.instr_done = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RST;
            ctrl_reg  <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next);
            if (state_reg == DECODE) begin
                op_reg <= bus.opcode;
            end
        end
    end

    assign bus.pc_we      = ctrl_reg.pc_we | ((state_reg == BEQ_EX) & bus.zero);
    assign bus.pc_src     = ctrl_reg.pc_src;
    assign bus.iord       = ctrl_reg.iord;
    assign bus.mem_we     = ctrl_reg.mem_we;
    assign bus.ir_we      = ctrl_reg.ir_we;
    assign bus.reg_dst    = ctrl_reg.reg_dst;
    assign bus.mem_to_reg = ctrl_reg.mem_to_reg;
    assign bus.reg_we     = ctrl_reg.reg_we;
    assign bus.alu_src_a  = ctrl_reg.alu_src_a;
    assign bus.alu_src_b  = ctrl_reg.alu_src_b;
    assign bus.alu_op     = ctrl_reg.alu_op;
    assign bus.instr_done = ctrl_reg.instr_done;
    assign bus.illegal    = (state_reg == DECODE) && !op_legal;
    assign bus.state      = state_reg;

endmodule
